wb_cmd_initiator: RTL and testbench

Wishbone classic-cycle master that turns a queued command stream into bus transactions toward the user-area slave fabric: the UART window at 0x30xx_xxxx and the exmem BRAM window at 0x38xx_xxxx. It supports single-beat and incrementing multi-beat read/write commands, one bus beat at a time. Each beat returns a response word. A timeout guards against unmapped addresses, where the fabric never acks. It drives test and DMA traffic in the same protocol the wrapper's slaves consume.

---
 rtl/wb_cmd_initiator_pkg.sv | 19 +
 rtl/wb_cmd_initiator_if.sv | 25 ++
 rtl/wb_timeout_ctr.sv | 34 +++
 rtl/wb_cmd_initiator.sv | 156 +++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_cmd_initiator_pkg.sv
// Shared types and constants for the Wishbone command initiator.
//   state_t      : command FSM states
//   ADDR_STRIDE  : byte increment between beats of a multi-beat command
//   UART_BASE    : top address byte of the UART slave window
//   EXMEM_BASE   : top address byte of the exmem BRAM slave window
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        BUS   = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] ADDR_STRIDE = 32'd4;
    localparam logic [7:0]  UART_BASE   = 8'h30;
    localparam logic [7:0]  EXMEM_BASE  = 8'h38;

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Wishbone classic-cycle bus between the command initiator and the slave fabric.
//   master : drives cyc/stb/we/sel/adr/dat_o, samples dat_i/ack
//   slave  : the opposite directions
interface wb_cmd_initiator_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Beat timeout counter: clear has priority, counts up while enabled and holds
// at the terminal value. expired is high when the count is TIMEOUT_CYCLES-1.
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   clr                : synchronous clear to 0
//   en                 : count enable
//   expired            : terminal count reached
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == TC);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic-cycle master: turns queued read/write commands into one
// bus beat at a time and returns one response word per beat.
//   wb_clk_i, wb_rst_i          : clock, async active-high reset
//   cmd_*                       : command stream (we, adr, sel, len = beats-1)
//   wdata_valid/ready, wdata    : write-data word stream, one word per write beat
//   rsp_valid/ready, rsp_*      : per-beat response (data, err, last)
//   wbm                         : Wishbone master port
//   busy                        : high whenever a command is in progress
//
// state | meaning
// IDLE  | waiting for a command
// WDATA | waiting for the write word of the current beat
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response held until consumed
module wb_cmd_initiator
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int LEN_W          = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_adr,
    input  logic [3:0]           cmd_sel,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [31:0]          wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 rsp_last,
    wb_cmd_initiator_if.master   wbm,
    output logic                 busy
);

    state_t           state;
    logic [LEN_W-1:0] beats_left;
    logic             tmo_clr;
    logic             tmo_en;
    logic             tmo_expired;

    // cmd_ready is forced low while reset is held, even though state sits in IDLE.
    assign cmd_ready = (state == IDLE) && !wb_rst_i;
    assign busy      = (state != IDLE);

    assign tmo_clr = ((state == IDLE) && cmd_valid) ||
                     ((state == RESP) && rsp_ready && !rsp_last);
    assign tmo_en  = (state == BUS) && !wbm.wbm_ack_i;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clr      (tmo_clr),
        .en       (tmo_en),
        .expired  (tmo_expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            beats_left    <= '0;
            wdata_ready   <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            rsp_last      <= 1'b0;
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_sel_o <= '0;
            wbm.wbm_adr_o <= '0;
            wbm.wbm_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm.wbm_we_o  <= cmd_we;
                        wbm.wbm_adr_o <= cmd_adr & ~32'd3;
                        wbm.wbm_sel_o <= cmd_sel;
                        beats_left    <= cmd_len;
                        if (cmd_we) begin
                            wdata_ready <= 1'b1;
                            state       <= WDATA;
                        end else begin
                            wbm.wbm_dat_o <= '0;
                            wbm.wbm_cyc_o <= 1'b1;
                            wbm.wbm_stb_o <= 1'b1;
                            state         <= BUS;
                        end
                    end
                end

                WDATA: begin
                    if (wdata_valid) begin
                        wbm.wbm_dat_o <= wdata;
                        wdata_ready   <= 1'b0;
                        wbm.wbm_cyc_o <= 1'b1;
                        wbm.wbm_stb_o <= 1'b1;
                        state         <= BUS;
                    end
                end

                BUS: begin
                    // Ack is checked first so an ack in the expiry cycle wins.
                    if (wbm.wbm_ack_i) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        rsp_data      <= wbm.wbm_we_o ? 32'd0 : wbm.wbm_dat_i;
                        rsp_err       <= 1'b0;
                        rsp_last      <= (beats_left == '0);
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else if (tmo_expired) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        rsp_data      <= '0;
                        rsp_err       <= 1'b1;
                        rsp_last      <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            beats_left    <= beats_left - 1'b1;
                            wbm.wbm_adr_o <= wbm.wbm_adr_o + ADDR_STRIDE;
                            if (wbm.wbm_we_o) begin
                                wdata_ready <= 1'b1;
                                state       <= WDATA;
                            end else begin
                                wbm.wbm_cyc_o <= 1'b1;
                                wbm.wbm_stb_o <= 1'b1;
                                state         <= BUS;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
module tb_wb_cmd_initiator;
    import wb_cmd_pkg::*;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;

    wb_cmd_initiator_if wbif ();

    wb_cmd_initiator #(.TIMEOUT_CYCLES(16), .LEN_W(8)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_sel     (cmd_sel),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_last    (rsp_last),
        .wbm         (wbif.master),
        .busy        (busy)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // Slave fabric model: exmem BRAM and UART windows ack after 'lat' stb cycles,
    // anything else never acks unless ack_all is set.
    int          lat = 0;
    bit          ack_all = 1'b0;
    int          wcnt = 0;
    logic [31:0] mem [0:63];
    logic        mapped;

    assign mapped = (wbif.wbm_adr_o[31:24] == EXMEM_BASE) || (wbif.wbm_adr_o[31:24] == UART_BASE);
    assign wbif.wbm_ack_i = wbif.wbm_stb_o && (mapped || ack_all) && (wcnt == lat);
    assign wbif.wbm_dat_i = (wbif.wbm_adr_o[31:24] == EXMEM_BASE) ? mem[wbif.wbm_adr_o[7:2]]
                                                                   : (wbif.wbm_adr_o ^ 32'hA5A5_0000);

    logic [31:0] beat_adr [$];
    logic [31:0] beat_dat [$];
    int          cyc_rises = 0;
    logic        prev_cyc = 1'b0;
    int          stb_run = 0;
    int          last_stb_len = 0;

    always @(posedge wb_clk_i) begin
        if (wbif.wbm_stb_o && !wbif.wbm_ack_i) wcnt <= wcnt + 1;
        else                                   wcnt <= 0;
        if (wbif.wbm_stb_o && wbif.wbm_ack_i) begin
            beat_adr.push_back(wbif.wbm_adr_o);
            beat_dat.push_back(wbif.wbm_dat_o);
            if (wbif.wbm_we_o && wbif.wbm_adr_o[31:24] == EXMEM_BASE)
                mem[wbif.wbm_adr_o[7:2]] <= wbif.wbm_dat_o;
        end
        prev_cyc <= wbif.wbm_cyc_o;
        if (wbif.wbm_cyc_o && !prev_cyc) cyc_rises <= cyc_rises + 1;
        if (wbif.wbm_stb_o) stb_run <= stb_run + 1;
        else if (stb_run > 0) begin
            last_stb_len <= stb_run;
            stb_run      <= 0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
        int k = 0;
        cmd_we = we; cmd_adr = adr; cmd_sel = 4'hF; cmd_len = len; cmd_valid = 1'b1;
        while (!cmd_ready && k < 64) begin @(negedge wb_clk_i); k++; end
        if (!cmd_ready) chk("cmd_wait", {31'd0, cmd_ready}, 32'd1);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
    endtask

    task automatic send_wdata(input logic [31:0] d);
        int k = 0;
        wdata = d; wdata_valid = 1'b1;
        while (!wdata_ready && k < 64) begin @(negedge wb_clk_i); k++; end
        if (!wdata_ready) chk("wdata_wait", {31'd0, wdata_ready}, 32'd1);
        @(negedge wb_clk_i);
        wdata_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < 64) begin @(negedge wb_clk_i); k++; end
        if (!rsp_valid) chk("rsp_wait", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic e, output logic l);
        wait_rsp();
        d = rsp_data; e = rsp_err; l = rsp_last;
        @(negedge wb_clk_i);
    endtask

    task automatic clear_mon();
        beat_adr.delete();
        beat_dat.delete();
    endtask

    logic [31:0] d, d2;
    logic        e, l, e2, l2;
    int          rises0;
    logic [31:0] exp4 [4];

    initial begin
        exp4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = exp4[i];
        wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
        cmd_len = '0; wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge wb_clk_i);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_cyc", {31'd0, wbif.wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wbif.wbm_stb_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Single write, zero-wait
        clear_mon();
        send_cmd(1'b1, 32'h3800_0010, 8'd0);
        send_wdata(32'hDEAD_BEEF);
        get_rsp(d, e, l);
        chk("wr1_beats", beat_adr.size(), 32'd1);
        chk("wr1_adr", beat_adr[0], 32'h3800_0010);
        chk("wr1_dat", beat_dat[0], 32'hDEAD_BEEF);
        chk("wr1_err", {31'd0, e}, 32'd0);
        chk("wr1_last", {31'd0, l}, 32'd1);
        chk("wr1_rdata", d, 32'd0);
        chk("wr1_mem", mem[4], 32'hDEAD_BEEF);

        // Read back with unaligned address bits, and 2-cycle latency check
        clear_mon();
        send_cmd(1'b0, 32'h3800_0013, 8'd0);
        chk("lat_c1_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge wb_clk_i);
        chk("lat_c2_valid", {31'd0, rsp_valid}, 32'd1);
        get_rsp(d, e, l);
        chk("rd_align_adr", beat_adr[0], 32'h3800_0010);
        chk("rd_align_data", d, 32'hDEAD_BEEF);

        // Burst read, 2-cycle ack latency
        lat = 2; clear_mon(); rises0 = cyc_rises;
        send_cmd(1'b0, 32'h3800_0000, 8'd3);
        for (int i = 0; i < 4; i++) begin
            get_rsp(d, e, l);
            chk($sformatf("burst_data%0d", i), d, exp4[i]);
            chk($sformatf("burst_last%0d", i), {31'd0, l}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("burst_adr%0d", i), beat_adr[i], 32'h3800_0000 + 32'(4 * i));
        end
        chk("burst_cyc_gaps", cyc_rises - rises0, 32'd4);
        chk("burst_stb_len", last_stb_len, 32'd3);

        // Timeout on unmapped address
        lat = 0; rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h2000_0000, 8'd0);
        wait_rsp();
        chk("tmo_busy_resp", {31'd0, busy}, 32'd1);
        rsp_ready = 1'b1;
        get_rsp(d, e, l);
        chk("tmo_stb_len", last_stb_len, 32'd16);
        chk("tmo_err", {31'd0, e}, 32'd1);
        chk("tmo_data", d, 32'd0);
        chk("tmo_last", {31'd0, l}, 32'd1);
        chk("tmo_busy_after", {31'd0, busy}, 32'd0);

        // Error abort drops remaining write beats
        send_cmd(1'b1, 32'h2000_0000, 8'd2);
        send_wdata(32'h1);
        get_rsp(d, e, l);
        chk("abort_err", {31'd0, e}, 32'd1);
        chk("abort_last", {31'd0, l}, 32'd1);
        @(negedge wb_clk_i);
        chk("abort_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Response backpressure on a len=1 read
        clear_mon(); rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h3800_0000, 8'd1);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_data%0d", i), rsp_data, 32'h11);
            chk($sformatf("bp_nostb%0d", i), {31'd0, wbif.wbm_stb_o}, 32'd0);
            @(negedge wb_clk_i);
        end
        rsp_ready = 1'b1;
        get_rsp(d, e, l);
        get_rsp(d2, e2, l2);
        chk("bp_d0", d, 32'h11);
        chk("bp_l0", {31'd0, l}, 32'd0);
        chk("bp_d1", d2, 32'h22);
        chk("bp_l1", {31'd0, l2}, 32'd1);
        chk("bp_beats", beat_adr.size(), 32'd2);

        // Write-data backpressure in a write burst
        clear_mon();
        send_cmd(1'b1, 32'h3800_0020, 8'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wbp_ready%0d", i), {31'd0, wdata_ready}, 32'd1);
            chk($sformatf("wbp_nostb%0d", i), {31'd0, wbif.wbm_stb_o}, 32'd0);
            @(negedge wb_clk_i);
        end
        send_wdata(32'hA1A1_0001);
        get_rsp(d, e, l);
        send_wdata(32'hA2A2_0002);
        get_rsp(d2, e2, l2);
        chk("wbp_l0", {31'd0, l}, 32'd0);
        chk("wbp_l1", {31'd0, l2}, 32'd1);
        chk("wbp_mem8", mem[8], 32'hA1A1_0001);
        chk("wbp_mem9", mem[9], 32'hA2A2_0002);
        chk("wbp_adr1", beat_adr[1], 32'h3800_0024);

        // Ack in the 16th stb cycle wins over expiry
        lat = 15;
        send_cmd(1'b0, 32'h3800_0004, 8'd0);
        get_rsp(d, e, l);
        chk("exp_ack_err", {31'd0, e}, 32'd0);
        chk("exp_ack_data", d, 32'h22);
        chk("exp_ack_stb_len", last_stb_len, 32'd16);

        // One cycle later than that is a timeout
        lat = 16;
        send_cmd(1'b0, 32'h3800_0004, 8'd0);
        get_rsp(d, e, l);
        chk("late_ack_err", {31'd0, e}, 32'd1);
        chk("late_ack_stb_len", last_stb_len, 32'd16);

        // Reset asserted mid-BUS drops cyc/stb immediately
        lat = 0;
        send_cmd(1'b0, 32'h2000_0000, 8'd0);
        repeat (3) @(negedge wb_clk_i);
        chk("midrst_stb_before", {31'd0, wbif.wbm_stb_o}, 32'd1);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("midrst_stb", {31'd0, wbif.wbm_stb_o}, 32'd0);
        chk("midrst_cyc", {31'd0, wbif.wbm_cyc_o}, 32'd0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);

        // Address wrap at the top of the space
        ack_all = 1'b1; clear_mon();
        send_cmd(1'b0, 32'hFFFF_FFFC, 8'd1);
        get_rsp(d, e, l);
        get_rsp(d2, e2, l2);
        chk("wrap_adr0", beat_adr[0], 32'hFFFF_FFFC);
        chk("wrap_adr1", beat_adr[1], 32'h0000_0000);
        chk("wrap_d0", d, 32'h5A5A_FFFC);
        chk("wrap_d1", d2, 32'hA5A5_0000);
        chk("wrap_l1", {31'd0, l2}, 32'd1);
        ack_all = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
